// File: rtl/matrix_mul_nxn_if.sv
// Operand/result bus of the N x N sequential matrix multiplier.
// The master loads operands and pulses start; the slave returns C with busy/done.
interface matrix_mul_nxn_if #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int CW = 2*DW + $clog2(N) + 1
);
  logic              start;
  logic              acc_mode;
  logic [N*N*DW-1:0] a_flat;
  logic [N*N*DW-1:0] b_flat;
  logic [N*N*CW-1:0] c_flat;
  logic              busy;
  logic              done;

  modport master (
    output start, acc_mode, a_flat, b_flat,
    input  c_flat, busy, done
  );

  modport slave (
    input  start, acc_mode, a_flat, b_flat,
    output c_flat, busy, done
  );
endinterface

// File: rtl/matrix_mul_nxn.sv
// Sequential N x N signed matrix multiplier: one time-shared MAC, row-major
// result write-back, optional accumulate into the previous C.
module matrix_mul_nxn #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int CW = 2*DW + $clog2(N) + 1
) (
  input  logic            clk,
  input  logic            rst,
  matrix_mul_nxn_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int AW = $clog2(N*N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic [N*N-1:0][DW-1:0] r_a;
  logic [N*N-1:0][DW-1:0] r_b;
  logic [N*N-1:0][CW-1:0] r_c;
  logic                   r_acc;
  logic [IW-1:0]          r_i, r_j, r_k;
  logic signed [CW-1:0]   r_sum;

  logic [AW-1:0]          w_aidx, w_bidx, w_cidx;
  logic signed [CW-1:0]   w_a, w_b, w_sum_next;
  logic                   w_klast, w_jlast, w_ilast;

  always_comb begin
    w_aidx     = AW'(r_i) * AW'(N) + AW'(r_k);
    w_bidx     = AW'(r_k) * AW'(N) + AW'(r_j);
    w_cidx     = AW'(r_i) * AW'(N) + AW'(r_j);
    w_a        = CW'($signed(r_a[w_aidx]));
    w_b        = CW'($signed(r_b[w_bidx]));
    w_sum_next = r_sum + w_a * w_b;
    w_klast    = (r_k == IW'(N-1));
    w_jlast    = (r_j == IW'(N-1));
    w_ilast    = (r_i == IW'(N-1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (w_klast && w_jlast && w_ilast) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= '0;
      r_acc <= 1'b0;
      r_i   <= '0;
      r_j   <= '0;
      r_k   <= '0;
      r_sum <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a   <= bus.a_flat;
            r_b   <= bus.b_flat;
            r_acc <= bus.acc_mode;
            r_i   <= '0;
            r_j   <= '0;
            r_k   <= '0;
            r_sum <= '0;
          end
        end
        S_RUN: begin
          if (!w_klast) begin
            r_sum <= w_sum_next;
            r_k   <= r_k + IW'(1);
          end else begin
            // Dot product complete: commit C[i][j] and step to the next element.
            r_c[w_cidx] <= r_acc ? (r_c[w_cidx] + w_sum_next) : w_sum_next;
            r_sum <= '0;
            r_k   <= '0;
            if (w_jlast) begin
              r_j <= '0;
              r_i <= w_ilast ? '0 : r_i + IW'(1);
            end else begin
              r_j <= r_j + IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.c_flat = r_c;
  assign bus.busy   = (r_state == S_RUN);
  assign bus.done   = (r_state == S_DONE);
endmodule

// File: tb/tb_matrix_mul_nxn.sv
// Scoreboarded bench for matrix_mul_nxn at N=2 and N=4 (DW=8).
// Directed vectors with hand-computed results, then random runs against a reference model.
module tb_matrix_mul_nxn;
  localparam int DW  = 8;
  localparam int CW2 = 18;
  localparam int CW4 = 19;
  localparam int A2  = 4*DW;
  localparam int C2  = 4*CW2;
  localparam int A4  = 16*DW;
  localparam int C4  = 16*CW4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_mul_nxn_if #(.N(2), .DW(DW), .CW(CW2)) if2 ();
  matrix_mul_nxn_if #(.N(4), .DW(DW), .CW(CW4)) if4 ();

  matrix_mul_nxn #(.N(2), .DW(DW), .CW(CW2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
  matrix_mul_nxn #(.N(4), .DW(DW), .CW(CW4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

  int checks   = 0;
  int failures = 0;

  logic [C2-1:0] q2[$];
  logic [C4-1:0] q4[$];
  logic [C4-1:0] prev4;

  // hand-computed results
  localparam logic [A2-1:0] M2_A    = {8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [A2-1:0] M2_I    = {8'd1, 8'd0, 8'd0, 8'd1};
  localparam logic [A2-1:0] M2_ONES = {4{8'd1}};
  localparam logic [C2-1:0] E2_ID   = {18'd4, 18'd3, 18'd2, 18'd1};
  localparam logic [C2-1:0] E2_TWO  = {4{18'd2}};
  localparam logic [C2-1:0] E2_FOUR = {4{18'd4}};
  localparam logic [A4-1:0] M4_NEG  = {16{8'h80}};
  localparam logic [A4-1:0] M4_POS  = {16{8'h7F}};
  localparam logic [C4-1:0] E4_POS  = {16{19'd65536}};
  localparam logic [C4-1:0] E4_NEG  = {16{19'd459264}}; // -65024 mod 2^19

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [C4-1:0] act, input logic [C4-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [C4-1:0] ref4(input logic [A4-1:0] a, input logic [A4-1:0] b,
                                         input logic acc, input logic [C4-1:0] prev);
    logic [C4-1:0]  r;
    longint         s;
    logic [63:0]    sv;
    logic [DW-1:0]  ea, eb;
    logic [CW4-1:0] ep;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 4; k++) begin
          ea = a[(i*4+k)*DW +: DW];
          eb = b[(k*4+j)*DW +: DW];
          s += longint'($signed(ea)) * longint'($signed(eb));
        end
        if (acc) begin
          ep = prev[(i*4+j)*CW4 +: CW4];
          s += longint'($signed(ep));
        end
        sv = s;
        r[(i*4+j)*CW4 +: CW4] = sv[CW4-1:0];
      end
    end
    return r;
  endfunction

  // Scoreboard monitors: each done pulse pops one expected result.
  always @(negedge clk) begin
    if (!rst && if2.done) begin
      if (q2.size() == 0) begin
        checks++; failures++;
        $display("FAIL done2_unexpected got=1 want=0");
      end else begin
        chkw("c2_result", C4'(if2.c_flat), C4'(q2.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && if4.done) begin
      if (q4.size() == 0) begin
        checks++; failures++;
        $display("FAIL done4_unexpected got=1 want=0");
      end else begin
        chkw("c4_result", if4.c_flat, q4.pop_front());
      end
    end
  end

  task automatic go2(input logic [A2-1:0] a, input logic [A2-1:0] b, input logic acc,
                     input logic [C2-1:0] exp);
    int cnt, bn;
    q2.push_back(exp);
    @(negedge clk);
    if2.a_flat = a; if2.b_flat = b; if2.acc_mode = acc; if2.start = 1'b1;
    @(negedge clk);
    if2.start = 1'b0; if2.a_flat = '0; if2.b_flat = '0; if2.acc_mode = 1'b0;
    cnt = 1; bn = 0;
    while (!if2.done && cnt < 100) begin
      if (if2.busy) bn++;
      @(negedge clk);
      cnt++;
    end
    chk("lat2", cnt, 9);
    chk("busy2_cycles", bn, 8);
    chk("busy2_at_done", if2.busy, 0);
    @(negedge clk);
    chk("done2_pulse", if2.done, 0);
  endtask

  task automatic go4(input logic [A4-1:0] a, input logic [A4-1:0] b, input logic acc,
                     input bit disturb, input logic [C4-1:0] exp);
    int cnt, bn;
    q4.push_back(exp);
    @(negedge clk);
    if4.a_flat = a; if4.b_flat = b; if4.acc_mode = acc; if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    cnt = 1; bn = 0;
    while (!if4.done && cnt < 300) begin
      if (if4.busy) bn++;
      if (disturb && cnt == 10) begin
        if4.a_flat = ~a; if4.b_flat = ~b; if4.acc_mode = ~acc; if4.start = 1'b1;
      end
      if (disturb && cnt == 11) if4.start = 1'b0;
      @(negedge clk);
      cnt++;
    end
    chk("lat4", cnt, 65);
    chk("busy4_cycles", bn, 64);
    chk("busy4_at_done", if4.busy, 0);
    if (disturb) if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    chk("done4_pulse", if4.done, 0);
    if (disturb) begin
      chk("start_in_done_ignored", if4.busy, 0);
      @(negedge clk);
      chk("start_in_done_idle", if4.busy, 0);
    end
  endtask

  initial begin
    logic [A4-1:0] ra, rb;
    logic          racc;
    logic [C4-1:0] e;
    if2.start = 1'b0; if2.acc_mode = 1'b0; if2.a_flat = '0; if2.b_flat = '0;
    if4.start = 1'b0; if4.acc_mode = 1'b0; if4.a_flat = '0; if4.b_flat = '0;
    prev4 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy2", if2.busy, 0);
    chk("rst_done2", if2.done, 0);
    chkw("rst_c2", C4'(if2.c_flat), '0);
    chk("rst_busy4", if4.busy, 0);
    chk("rst_done4", if4.done, 0);
    chkw("rst_c4", if4.c_flat, '0);

    go2(M2_A, M2_I, 1'b0, E2_ID);
    go2(M2_ONES, M2_ONES, 1'b0, E2_TWO);
    go2(M2_ONES, M2_ONES, 1'b1, E2_FOUR);
    repeat (5) @(negedge clk);
    chkw("c2_hold_idle", C4'(if2.c_flat), C4'(E2_FOUR));

    go4(M4_NEG, M4_NEG, 1'b0, 1'b0, E4_POS);
    go4(M4_NEG, M4_POS, 1'b0, 1'b1, E4_NEG);

    // Abort a run part way through.
    @(negedge clk);
    if4.a_flat = M4_POS; if4.b_flat = M4_POS; if4.acc_mode = 1'b0; if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", if4.busy, 0);
    chk("abort_done", if4.done, 0);
    chkw("abort_c4", if4.c_flat, '0);
    @(negedge clk);
    rst = 1'b0;
    prev4 = '0;
    repeat (80) @(negedge clk);
    chk("abort_no_busy", if4.busy, 0);

    for (int t = 0; t < 100; t++) begin
      for (int el = 0; el < 16; el++) begin
        ra[el*DW +: DW] = DW'($urandom);
        rb[el*DW +: DW] = DW'($urandom);
      end
      racc  = 1'($urandom_range(0, 1));
      e     = ref4(ra, rb, racc, prev4);
      prev4 = e;
      go4(ra, rb, racc, 1'b0, e);
    end

    repeat (3) @(negedge clk);
    chk("q2_drained", q2.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/matrix_mul_nxn.md
# matrix_mul_nxn

Parametrised sequential N×N signed matrix multiplier, generalising the 2×2 multiply block to arbitrary size. It adds operand capture, a single time-shared MAC, a start/busy/done handshake and an optional accumulate mode (C ← C + A·B). It sits behind a control FSM or CPU register bank that loads flat operand buses and waits for `done`.

## Interface
- `N`, 4: matrix dimension, ≥2.
- `DW`, 8: signed element width of A and B.
- `CW`, 2*DW+$clog2(N)+1: signed result and accumulator width; no overflow is possible for a single product sum.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request a multiply; sampled only in IDLE.
- `acc_mode` in 1: sampled with `start`. 0: C = A·B. 1: C = C_prev + A·B.
- `a_flat` in N*N*DW: element A[i][k] at bits [(i*N+k)*DW +: DW].
- `b_flat` in N*N*DW: element B[k][j], same packing.
- `c_flat` out N*N*CW: registered C[i][j] at [(i*N+j)*CW +: CW].
- `busy` out 1: high while a multiply is in progress.
- `done` out 1: one-cycle pulse when `c_flat` is fully updated.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: performs one MAC per cycle.
  - DONE: asserts `done` for one cycle, then returns to IDLE.
- IDLE with `start`=1:
  - Captures `a_flat`, `b_flat` and `acc_mode` into internal registers.
  - Clears indices i, j, k and the running sum, then goes to RUN.
  - Operand inputs may change freely after this capture cycle.
- Each RUN cycle computes sum_next = sum + sext(A[i][k]) * sext(B[k][j]), signed, full CW width.
- When k < N-1: sum ← sum_next, k++.
- When k = N-1:
  - Writes C[i][j] ← sum_next, or C[i][j] + sum_next in accumulate mode.
  - Clears sum and k; j++. On j wrap to 0, i++.
- After the write of C[N-1][N-1], the FSM goes to DONE.
- Elements of `c_flat` update individually during RUN in row-major order.
- `c_flat` is guaranteed fully consistent only from the `done` cycle until the next accepted `start`.
- Accumulate mode:
  - Uses the previous `c_flat` contents.
  - Wraps modulo 2^CW on overflow; no saturation.
- `start` while in RUN or DONE is ignored: not queued, no effect on operands or mode.
- `c_flat` holds its value indefinitely in IDLE.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `c_flat`=0, internal operand registers, indices and sum all 0.
- Reset mid-RUN aborts the operation immediately. No `done` pulse follows, and `c_flat` returns to 0.
- Start accepted at edge T0 (start=1 in IDLE):
  - `busy`=1 from T0+1 through T0+N³.
  - `done`=1 in cycle T0+N³+1 only; `busy`=0 in that cycle.
- Latency from accepted start to `done` is N³+1 cycles: 65 for N=4, 9 for N=2.
- Minimum start-to-start interval is N³+2 cycles. A `start` held high during DONE is not accepted. A `start` in the cycle after DONE (IDLE) is accepted.
- C[i][j] becomes visible on `c_flat` at cycle T0+(i*N+j+1)*N+1.
- There are no combinational paths from inputs to outputs.

## Test plan
- Identity, N=2: A=[[1,2],[3,4]], B=I, acc_mode=0 → C=[[1,2],[3,4]]; `done` 9 cycles after the start edge; `busy` high for exactly 8 cycles.
- Signed extremes, N=4, DW=8: all A=-128, all B=-128 → every C=65536, no overflow at CW=19. All A=-128, all B=127 → every C=-65024.
- Accumulate: run A=B=[[1,1],[1,1]] with mode 0 → C=all 2. Repeat with acc_mode=1 → C=all 4.
- Operand capture and ignored start, N=4:
  - Change `a_flat` and pulse `start` during RUN.
  - Result matches the operands captured at the accepted start.
  - Exactly one `done` pulse, at +65.
- Reset mid-operation: assert `rst` at cycle 20 of a N=4 run → `busy`, `done` and `c_flat` go to 0 immediately; no `done` later.
- A new start then completes normally, matching a software reference model for 100 random matrices.
